// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: active-low hex segment codes and nibble decode helper
package seven_seg_pkg;
    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;
    localparam logic [6:0] SEG_A   = 7'b0001000;
    localparam logic [6:0] SEG_B   = 7'b0000011;
    localparam logic [6:0] SEG_C   = 7'b1000110;
    localparam logic [6:0] SEG_D   = 7'b0100001;
    localparam logic [6:0] SEG_E   = 7'b0000110;
    localparam logic [6:0] SEG_F   = 7'b0001110;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        case (nibble)
            4'h0: return SEG_0;
            4'h1: return SEG_1;
            4'h2: return SEG_2;
            4'h3: return SEG_3;
            4'h4: return SEG_4;
            4'h5: return SEG_5;
            4'h6: return SEG_6;
            4'h7: return SEG_7;
            4'h8: return SEG_8;
            4'h9: return SEG_9;
            4'hA: return SEG_A;
            4'hB: return SEG_B;
            4'hC: return SEG_C;
            4'hD: return SEG_D;
            4'hE: return SEG_E;
            default: return SEG_F;
        endcase
    endfunction
endpackage

// File: rtl/seven_seg_decode.sv
// seven_seg_decode: combinational hex nibble to active-low segment pattern
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segment
);
    assign segment = hex_to_seg(nibble);
endmodule

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: multiplexed hex display driver with blanking and frame-synchronous update
module seven_segment_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    blank_en,
    output logic [6:0]              segment,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    pending
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] disp_value, sh_value;
    logic [NUM_DIGITS-1:0]   disp_dp, sh_dp;
    logic                    disp_blank_en, sh_blank_en;
    logic                    tc, frame_end, lz;
    logic [NUM_DIGITS-1:0]   blank;
    logic [3:0]              nibble;
    logic [6:0]              dec_seg;

    assign tc        = cnt == CNT_W'(REFRESH_DIV - 1);
    assign frame_end = tc && idx == IDX_W'(NUM_DIGITS - 1);
    assign nibble    = disp_value[{idx, 2'b00} +: 4];

    // a digit blanks only while every digit from it up to the MSD is zero
    always_comb begin
        blank = '0;
        lz = disp_blank_en;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lz = lz && disp_value[4*i +: 4] == 4'h0;
            blank[i] = lz;
        end
    end

    seven_seg_decode u_dec (
        .nibble  (nibble),
        .segment (dec_seg)
    );

    // shadow mirrors display whenever nothing is pending, so commit can always take shadow
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt           <= '0;
            idx           <= '0;
            disp_value    <= '0;
            disp_dp       <= '0;
            disp_blank_en <= 1'b0;
            sh_value      <= '0;
            sh_dp         <= '0;
            sh_blank_en   <= 1'b0;
            pending       <= 1'b0;
            segment       <= SEG_OFF;
            dp_out        <= 1'b1;
            anode         <= '1;
        end else begin
            cnt <= tc ? '0 : cnt + 1'b1;
            if (tc)
                idx <= idx == IDX_W'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
            if (load) begin
                sh_value    <= value;
                sh_dp       <= dp;
                sh_blank_en <= blank_en;
            end
            if (frame_end) begin
                disp_value    <= load ? value : sh_value;
                disp_dp       <= load ? dp : sh_dp;
                disp_blank_en <= load ? blank_en : sh_blank_en;
            end
            pending <= frame_end ? 1'b0 : pending | load;
            segment <= blank[idx] ? SEG_OFF : dec_seg;
            dp_out  <= blank[idx] | ~disp_dp[idx];
            anode   <= ~(NUM_DIGITS'(1) << idx);
        end
    end
endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner: directed and random checks against a cycle-count based display model
module tb_seven_segment_scanner;
    localparam int N   = 4;
    localparam int DIV = 4;
    localparam int FRAME = N * DIV;

    logic clk = 1'b0;
    logic reset, load, blank_en;
    logic [15:0] value;
    logic [3:0] dp;
    logic [6:0] segment;
    logic dp_out, pending;
    logic [3:0] anode;

    int tests = 0;
    int fails = 0;
    int k = 0;

    logic [15:0] m_val, s_val;
    logic [3:0]  m_dp, s_dp;
    logic        m_be, s_be, m_pend;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seven_segment_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .value    (value),
        .dp       (dp),
        .blank_en (blank_en),
        .segment  (segment),
        .dp_out   (dp_out),
        .anode    (anode),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s k=%0d got %b expected %b", tag, k, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic ld, input logic [15:0] v,
                        input logic [3:0] d, input logic b);
        logic [6:0] e_seg;
        logic [3:0] e_an;
        logic e_dp, bl;
        int i, msd;
        reset = rst; load = ld; value = v; dp = d; blank_en = b;
        if (rst) begin
            e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
        end else begin
            i = (k / DIV) % N;
            msd = 0;
            for (int j = 0; j < N; j++)
                if (m_val[4*j +: 4] != 4'h0) msd = j;
            bl = m_be && i > msd;
            e_seg = bl ? 7'h7F : seg_tab[m_val[4*i +: 4]];
            e_dp = bl ? 1'b1 : ~m_dp[i];
            e_an = ~(4'b0001 << i);
        end
        if (rst) begin
            m_val = '0; m_dp = '0; m_be = 1'b0;
            s_val = '0; s_dp = '0; s_be = 1'b0;
            m_pend = 1'b0; k = 0;
        end else begin
            if (k % FRAME == FRAME - 1) begin
                if (ld) begin
                    m_val = v; m_dp = d; m_be = b;
                end else if (m_pend) begin
                    m_val = s_val; m_dp = s_dp; m_be = s_be;
                end
                m_pend = 1'b0;
            end else if (ld) begin
                s_val = v; s_dp = d; s_be = b; m_pend = 1'b1;
            end
            k++;
        end
        @(posedge clk);
        #1;
        check("segment", segment, e_seg);
        check("dp_out", 7'(dp_out), 7'(e_dp));
        check("anode", 7'(anode), 7'(e_an));
        check("pending", 7'(pending), 7'(m_pend));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'($urandom), 4'($urandom), 1'($urandom));
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic b);
        step(1'b0, 1'b1, v, d, b);
    endtask

    task automatic go_to(input int ph);
        for (int n = 0; n < FRAME && (k % FRAME) != ph; n++) idle();
    endtask

    initial begin
        m_val = '0; m_dp = '0; m_be = 1'b0;
        s_val = '0; s_dp = '0; s_be = 1'b0; m_pend = 1'b0;
        repeat (3) step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
        repeat (20) idle();
        go_to(2);
        do_load(16'h12AF, 4'b0100, 1'b0);
        repeat (32) idle();
        go_to(5);
        do_load(16'h0050, 4'b1000, 1'b1);
        repeat (32) idle();
        do_load(16'h0000, 4'b1111, 1'b1);
        repeat (32) idle();
        go_to(4);
        do_load(16'h1111, 4'b0000, 1'b0);
        repeat (20) idle();
        go_to(1);
        do_load(16'h2222, 4'b0001, 1'b0);
        idle();
        do_load(16'h3333, 4'b0010, 1'b0);
        repeat (20) idle();
        go_to(FRAME - 1);
        do_load(16'h4444, 4'b0100, 1'b0);
        repeat (20) idle();
        go_to(8);
        do_load(16'h5555, 4'b1111, 1'b0);
        step(1'b1, 1'b1, 16'h6666, 4'hF, 1'b1);
        repeat (20) idle();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0)
                step(1'b1, 1'($urandom), 16'($urandom), 4'($urandom), 1'($urandom));
            else if ($urandom_range(0, 5) == 0)
                do_load($urandom_range(0, 3) == 0 ? 16'($urandom_range(0, 255)) : 16'($urandom),
                        4'($urandom), 1'($urandom));
            else
                idle();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
